// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one byte-wide UART transmitter.
// Optional mid-packet stall timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BUFFER_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ*BUFFER_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [BUFFER_WIDTH-1:0]         tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCEPT    = 3'd1,
    ISSUE     = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e                  state_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           last_owner_q;
  logic [BUFFER_WIDTH-1:0] hold_q;
  logic                    last_q;
  logic                    tx_valid_q;
  logic                    busy_q;
  logic [NUM_REQ-1:0]      req_ready_q;

  logic [GW-1:0]           pick_d;
  logic [BUFFER_WIDTH-1:0] sel_data_d;
  logic                    sel_valid_d;
  logic                    sel_last_d;

  // Scan from last_owner+1 upward (mod NUM_REQ); the closest valid requester wins.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] r;
    int            idx;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (v[idx]) r = GW'(idx);
    end
    return r;
  endfunction

  always_comb begin
    pick_d      = rr_pick(req_valid, last_owner_q);
    sel_data_d  = req_data[int'(grant_q)*BUFFER_WIDTH +: BUFFER_WIDTH];
    sel_valid_d = req_valid[grant_q];
    sel_last_d  = req_last[grant_q];
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_owner_q  <= GW'(NUM_REQ - 1);
      hold_q        <= '0;
      last_q        <= 1'b0;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q     <= pick_d;
            req_ready_q <= ONE_HOT0 << pick_d;
            busy_q      <= 1'b1;
            state_q     <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (sel_valid_d) begin
            hold_q      <= sel_data_d;
            last_q      <= sel_last_d;
            req_ready_q <= '0;
            tx_valid_q  <= 1'b1;
            state_q     <= ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
          end else if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Requester went quiet mid-packet for too long: drop its grant.
            last_owner_q  <= grant_q;
            req_ready_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            stall_cnt_q   <= '0;
            state_q       <= IDLE;
          end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
`endif
          end
        end
        ISSUE: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!tx_ready) state_q <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          // tx_ready returning high marks the end of the UART frame.
          if (tx_ready) begin
            if (last_q) begin
              last_owner_q <= grant_q;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              req_ready_q <= ONE_HOT0 << grant_q;
              state_q     <= ACCEPT;
            end
          end
        end
        default: begin
          tx_valid_q  <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = hold_q;
  assign tx_valid  = tx_valid_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes,
// TIMEOUT_CYCLES=16); the stall section adapts to UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  held  = 8'h00;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .BUFFER_WIDTH  (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic v, input logic l);
    req_data[8*i +: 8] = d;
    req_valid[i]       = v;
    req_last[i]        = l;
  endtask

  // Wait (bounded) for a byte to be offered to the UART, then check it.
  task automatic wait_issue(input string tag, input logic [7:0] d, input logic [1:0] g);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_txvalid"}, 32'(tx_valid), 32'd1);
    chk({tag, "_txdata"}, 32'(tx_data), 32'(d));
    chk({tag, "_grant"}, 32'(grant_id), 32'(g));
    held = d;
  endtask

  // Behave like the UART: accept the byte, stay busy lowc cycles, go idle again.
  task automatic finish_frame(input string tag, input int lowc);
    step();
    chk({tag, "_txvalid_drop"}, 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < lowc; i++) begin
      step();
      chk({tag, "_hold_txvalid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_hold_txdata"}, 32'(tx_data), 32'(held));
    end
    tx_ready = 1'b1;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    step();
    step();
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txvalid", 32'(tx_valid), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single requester, minimum latency, 100-cycle data hold
    set_req(1, 8'hA5, 1'b1, 1'b1);
    step();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'b0010);
    chk("t1_txvalid_early", 32'(tx_valid), 32'd0);
    step();
    chk("t1_txvalid", 32'(tx_valid), 32'd1);
    chk("t1_txdata", 32'(tx_data), 32'hA5);
    chk("t1_ready_drop", 32'(req_ready), 32'd0);
    held = 8'hA5;
    set_req(1, 8'h00, 1'b0, 1'b0);
    finish_frame("t1", 100);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_grant_end", 32'(grant_id), 32'd1);

    // Reset while in ISSUE
    set_req(1, 8'h77, 1'b1, 1'b1);
    wait_issue("t2", 8'h77, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("t2_rst_txvalid", 32'(tx_valid), 32'd0);
    chk("t2_rst_busy", 32'(busy), 32'd0);
    chk("t2_rst_grant", 32'(grant_id), 32'd0);
    chk("t2_rst_txdata", 32'(tx_data), 32'd0);
    set_req(1, 8'h00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_txvalid", 32'(tx_valid), 32'd0);

    // Contention after reset: 0 then 2, twice
    set_req(0, 8'h40, 1'b1, 1'b1);
    set_req(2, 8'h42, 1'b1, 1'b1);
    wait_issue("t3a", 8'h40, 2'd0);
    set_req(0, 8'h00, 1'b0, 1'b0);
    finish_frame("t3a", 2);
    wait_issue("t3b", 8'h42, 2'd2);
    set_req(2, 8'h00, 1'b0, 1'b0);
    finish_frame("t3b", 2);
    set_req(0, 8'h50, 1'b1, 1'b1);
    set_req(2, 8'h52, 1'b1, 1'b1);
    wait_issue("t3c", 8'h50, 2'd0);
    set_req(0, 8'h00, 1'b0, 1'b0);
    finish_frame("t3c", 2);
    wait_issue("t3d", 8'h52, 2'd2);
    set_req(2, 8'h00, 1'b0, 1'b0);
    finish_frame("t3d", 2);

    // Requester 3 alone, leaving the pointer at 3 so requester 0 ranks first
    set_req(3, 8'h3A, 1'b1, 1'b1);
    wait_issue("t4", 8'h3A, 2'd3);
    set_req(3, 8'h00, 1'b0, 1'b0);
    finish_frame("t4", 2);

    // Packet lock: 3-byte packet from 0 while 3 waits
    set_req(0, 8'h11, 1'b1, 1'b0);
    set_req(3, 8'h3C, 1'b1, 1'b1);
    wait_issue("t5a", 8'h11, 2'd0);
    set_req(0, 8'h22, 1'b1, 1'b0);
    finish_frame("t5a", 2);
    chk("t5_locked_busy", 32'(busy), 32'd1);
    chk("t5_locked_ready", 32'(req_ready), 32'b0001);
    wait_issue("t5b", 8'h22, 2'd0);
    set_req(0, 8'h33, 1'b1, 1'b1);
    finish_frame("t5b", 2);
    wait_issue("t5c", 8'h33, 2'd0);
    set_req(0, 8'h00, 1'b0, 1'b0);
    finish_frame("t5c", 2);
    wait_issue("t5d", 8'h3C, 2'd3);
    set_req(3, 8'h00, 1'b0, 1'b0);
    finish_frame("t5d", 2);

    // Mid-packet stall by requester 2 with requester 3 waiting
    set_req(2, 8'h2A, 1'b1, 1'b0);
    set_req(3, 8'h3D, 1'b1, 1'b1);
    wait_issue("t6a", 8'h2A, 2'd2);
    set_req(2, 8'h00, 1'b0, 1'b0);
    finish_frame("t6a", 2);
    chk("t6_stall_ready", 32'(req_ready), 32'b0100);
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t6_tmo_quiet", 32'(timeout_err), 32'd0);
      chk("t6_busy_quiet", 32'(busy), 32'd1);
    end
    step();
    chk("t6_tmo_pulse", 32'(timeout_err), 32'd1);
    chk("t6_tmo_busy", 32'(busy), 32'd0);
    step();
    chk("t6_tmo_clear", 32'(timeout_err), 32'd0);
    chk("t6_next_grant", 32'(grant_id), 32'd3);
    chk("t6_next_busy", 32'(busy), 32'd1);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_tmo_tied", 32'(timeout_err), 32'd0);
    end
    chk("t6_wait_busy", 32'(busy), 32'd1);
    chk("t6_wait_grant", 32'(grant_id), 32'd2);
    chk("t6_wait_ready", 32'(req_ready), 32'b0100);
    set_req(2, 8'h2B, 1'b1, 1'b1);
    wait_issue("t6b", 8'h2B, 2'd2);
    set_req(2, 8'h00, 1'b0, 1'b0);
    finish_frame("t6b", 2);
`endif
    wait_issue("t6c", 8'h3D, 2'd3);
    set_req(3, 8'h00, 1'b0, 1'b0);
    finish_frame("t6c", 2);
    chk("t6_end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter BUFFER_WIDTH, default 8: byte width, matching the UART transmitter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: mid-packet stall limit in clocks.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_data, input, NUM_REQ*BUFFER_WIDTH bits: byte of requester i at slice [i*BUFFER_WIDTH +: BUFFER_WIDTH].
REQ-007 SHALL have port req_valid, input, NUM_REQ bits: requester byte valid.
REQ-008 SHALL have port req_last, input, NUM_REQ bits: marks the final byte of a packet.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: byte accepted when both ready and valid are high.
REQ-010 SHALL have port tx_data, output, BUFFER_WIDTH bits: connects to UART write_data.
REQ-011 SHALL have port tx_valid, output, 1 bit: connects to UART write_valid.
REQ-012 SHALL have port tx_ready, input, 1 bit: connects to UART write_ready, which is high only while the transmitter is idle.
REQ-013 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: current or last owner.
REQ-014 SHALL have port busy, output, 1 bit: a packet grant is held.
REQ-015 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-016 SHALL implement states IDLE, ACCEPT, ISSUE, WAIT_LOW and WAIT_HIGH; any unreachable encoding SHALL return to IDLE on the next clock.
REQ-017 In IDLE with any req_valid high, SHALL register as grant_id the first valid requester in round-robin order starting at (last_owner+1) mod NUM_REQ, and SHALL go to ACCEPT.
REQ-018 In IDLE with no req_valid high, SHALL stay in IDLE and hold grant_id.
REQ-019 In ACCEPT, SHALL drive req_ready[grant_id]=1, all other req_ready bits 0, and all req_ready bits 0 in every other state.
REQ-020 In ACCEPT, on a handshake SHALL capture the data into a hold register and req_last into last_q, then go to ISSUE.
REQ-021 In ISSUE, SHALL drive tx_valid=1; on tx_ready=1 SHALL go to WAIT_LOW.
REQ-022 In WAIT_LOW, SHALL drive tx_valid=0 and SHALL go to WAIT_HIGH once tx_ready=0.
REQ-023 In WAIT_HIGH, once tx_ready=1: if last_q=1, SHALL set last_owner to grant_id and go to IDLE; otherwise SHALL go to ACCEPT.
REQ-024 tx_data SHALL equal the hold register and SHALL stay stable from ISSUE entry until WAIT_HIGH exits, because the UART samples write_data throughout the frame.
REQ-025 Grant SHALL be packet-locked: other requesters are never served between the first byte of a packet and its req_last byte.
REQ-026 A single-byte packet (req_last=1 on the first byte) SHALL release the grant after one frame.
REQ-027 Minimum arbitration latency SHALL be: req_valid in IDLE, then one clock to ACCEPT, then handshake, then tx_valid on the next clock.
REQ-028 busy SHALL be 1 in ACCEPT, ISSUE, WAIT_LOW and WAIT_HIGH.
REQ-029 Round-robin pointer: last_owner=NUM_REQ-1 SHALL wrap so that requester 0 has top priority.
REQ-030 Requesters SHALL hold req_data and req_last stable while req_valid=1 and req_ready=0; the arbiter SHALL NOT check this.

Reset
REQ-031 Asserting rst_n low at any time SHALL immediately force the following: state=IDLE, last_owner=NUM_REQ-1, grant_id=0, tx_data=0, tx_valid=0, req_ready=0, busy=0, timeout_err=0, and the timeout counter=0.
REQ-032 Reset mid-frame SHALL abandon the packet; the first post-reset grant SHALL go to requester 0 if it is valid.

Configuration
REQ-033 With UART_ARB_TIMEOUT_EN defined, a counter SHALL count consecutive ACCEPT cycles with req_valid[grant_id]=0 and clear on handshake or state exit.
REQ-034 With UART_ARB_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the block SHALL go to IDLE, set last_owner=grant_id, and pulse timeout_err for one cycle.
REQ-035 Without UART_ARB_TIMEOUT_EN, ACCEPT SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-036 Single requester: requester 1 sends 0xA5 with last=1 -> tx_data=0xA5 with one tx_valid handshake, grant_id=1, busy drops after tx_ready returns high.
REQ-037 Contention after reset: requesters 0 and 2 are valid simultaneously -> requester 0 is served first, then 2; with a repeat of both, 0 is served before 2 again, since the pointer now sits at 2.
REQ-038 Packet lock: requester 0 sends a 3-byte packet 0x11, 0x22, 0x33 while requester 3 is valid -> tx sees 0x11, 0x22, 0x33 before any byte from 3.
REQ-039 Data hold: hold tx_ready low for 100 clocks after the handshake -> tx_data stays unchanged and tx_valid=0 throughout.
REQ-040 Timeout: with UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, requester 2 stalls after its first byte -> timeout_err pulses at stall cycle 16 and requester 3 is granted next.
REQ-041 Reset: assert rst_n low in ISSUE -> tx_valid=0 and busy=0 immediately, and the state is IDLE on release.
